param_code_lock: RTL and testbench

PARAM_CODE_LOCK -- requirements
Module: param_code_lock

---
 rtl/param_code_lock.sv | 195 +++++++++++++++++++
 tb/tb_param_code_lock.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_code_lock.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | param_code_lock: one-hot keypad code lock with entry timeout,         |
// | programmable code, failure counting and timed lockout.  Rev 1.0       |
// +-----------------------------------------------------------------------+
module param_code_lock #(
  parameter int N_BTN     = 4,
  parameter int CODE_LEN  = 4,
  parameter logic [CODE_LEN*$clog2(N_BTN+1)-1:0] DEFAULT_CODE = {3'd4, 3'd2, 3'd3, 3'd1},
  parameter int TIMEOUT   = 10,
  parameter int OPEN_HOLD = 20,
  parameter int FAIL_HOLD = 10,
  parameter int MAX_FAIL  = 3,
  parameter int LOCK_HOLD = 50
) (
  input  logic                                   clk,
  input  logic                                   rs,
  input  logic [N_BTN:1]                         btn,
  input  logic                                   set_code,
  input  logic [CODE_LEN*$clog2(N_BTN+1)-1:0]    code_in,
  output logic                                   led_green,
  output logic                                   led_red,
  output logic                                   locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]          fail_cnt
);

  localparam int DW       = $clog2(N_BTN + 1);
  localparam int FW       = $clog2(MAX_FAIL + 1);
  localparam int IW       = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int M1       = (TIMEOUT > OPEN_HOLD) ? TIMEOUT : OPEN_HOLD;
  localparam int M2       = (FAIL_HOLD > LOCK_HOLD) ? FAIL_HOLD : LOCK_HOLD;
  localparam int HOLD_MAX = (M1 > M2) ? M1 : M2;
  localparam int TW       = $clog2(HOLD_MAX + 1);

  localparam logic [TW-1:0] T_ENTRY_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_OPEN_LAST  = TW'(OPEN_HOLD - 1);
  localparam logic [TW-1:0] T_FAIL_LAST  = TW'(FAIL_HOLD - 1);
  localparam logic [TW-1:0] T_LOCK_LAST  = TW'(LOCK_HOLD - 1);
  localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);
  localparam logic [IW-1:0] LAST_IDX     = IW'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_FAIL    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [N_BTN:1]             btn_q;
  logic [TW-1:0]              timer_q, timer_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       mism_q, mism_d;
  logic [CODE_LEN*DW-1:0]     code_q, code_d;
  logic [FW-1:0]              fail_cnt_q, fail_cnt_d;
  logic                       led_green_q, led_green_d;
  logic                       led_red_q, led_red_d;
  logic                       locked_q, locked_d;

  logic                       press;
  logic                       digit_ok;
  logic [DW-1:0]              press_digit;
  logic [DW-1:0]              code_digit;
  logic [FW-1:0]              fail_inc;
  logic                       finish_entry;
  logic                       entry_bad;

  assign press = (btn != '0) && (btn != btn_q);

  always_comb begin
    press_digit = '0;
    for (int i = 1; i <= N_BTN; i++) begin
      if (btn[i]) press_digit = DW'(i);
    end
  end

  // idx_q is zero in IDLE, so the same select serves the first digit
  always_comb begin
    code_digit = '0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (idx_q == IW'(k)) code_digit = code_q[k*DW +: DW];
    end
  end

  // A multi-button press is digit 0 and can never match
  assign digit_ok = $onehot(btn) && (press_digit == code_digit);
  assign fail_inc = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FW'(1);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    mism_d       = mism_q;
    code_d       = code_q;
    fail_cnt_d   = fail_cnt_q;
    finish_entry = 1'b0;
    entry_bad    = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (press) begin
          mism_d  = ((state_q == S_ENTRY) && mism_q) || !digit_ok;
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            finish_entry = 1'b1;
            entry_bad    = mism_d;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_ENTRY;
          end
        end else if (state_q == S_ENTRY) begin
          if (timer_q == T_ENTRY_LAST) begin
            finish_entry = 1'b1;
            entry_bad    = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_OPEN: begin
        if (set_code) begin
          code_d  = code_in;
          timer_d = '0;
        end else if (timer_q == T_OPEN_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_FAIL: begin
        if (timer_q == T_FAIL_LAST) state_d = S_IDLE;
        else                        timer_d = timer_q + TW'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == T_LOCK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish_entry) begin
      timer_d = '0;
      idx_d   = '0;
      mism_d  = 1'b0;
      if (!entry_bad) begin
        state_d    = S_OPEN;
        fail_cnt_d = '0;
      end else begin
        fail_cnt_d = fail_inc;
        state_d    = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_FAIL;
      end
    end
  end

  assign led_green_d = (state_d == S_OPEN);
  assign led_red_d   = (state_d == S_FAIL) || (state_d == S_LOCKOUT);
  assign locked_d    = (state_d == S_LOCKOUT);

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q     <= S_IDLE;
      btn_q       <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      mism_q      <= 1'b0;
      code_q      <= DEFAULT_CODE;
      fail_cnt_q  <= '0;
      led_green_q <= 1'b0;
      led_red_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      mism_q      <= mism_d;
      code_q      <= code_d;
      fail_cnt_q  <= fail_cnt_d;
      led_green_q <= led_green_d;
      led_red_q   <= led_red_d;
      locked_q    <= locked_d;
    end
  end

  assign led_green = led_green_q;
  assign led_red   = led_red_q;
  assign locked    = locked_q;
  assign fail_cnt  = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_param_code_lock.sv
`default_nettype none
// tb_param_code_lock: directed scenarios plus random stimulus checked every
// cycle against an abstract model of the lock (digit queue + countdowns).
module tb_param_code_lock;

  localparam int CODE_LEN  = 4;
  localparam int TIMEOUT   = 10;
  localparam int OPEN_HOLD = 20;
  localparam int FAIL_HOLD = 10;
  localparam int MAX_FAIL  = 3;
  localparam int LOCK_HOLD = 50;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_FAIL  = 3;
  localparam int M_LOCK  = 4;

  logic        clk = 1'b0;
  logic        rs = 1'b0;
  logic [4:1]  btn = '0;
  logic        set_code = 1'b0;
  logic [11:0] code_in = '0;
  logic        led_green, led_red, locked;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  param_code_lock dut (
    .clk       (clk),
    .rs        (rs),
    .btn       (btn),
    .set_code  (set_code),
    .code_in   (code_in),
    .led_green (led_green),
    .led_red   (led_red),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_mode = M_IDLE;
  int         m_code[CODE_LEN] = '{1, 3, 2, 4};
  int         m_ent[$];
  int         m_since = 0;
  int         m_left = 0;
  int         m_fails = 0;
  logic [4:1] m_prev = '0;

  function automatic void m_fail();
    m_ent.delete();
    m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
    if (m_fails == MAX_FAIL) begin
      m_mode = M_LOCK;
      m_left = LOCK_HOLD;
    end else begin
      m_mode = M_FAIL;
      m_left = FAIL_HOLD;
    end
  endfunction

  function automatic void m_finish();
    bit ok = 1'b1;
    for (int k = 0; k < CODE_LEN; k++)
      if (m_ent[k] == 0 || m_ent[k] != m_code[k]) ok = 1'b0;
    m_ent.delete();
    if (ok) begin
      m_mode  = M_OPEN;
      m_left  = OPEN_HOLD;
      m_fails = 0;
    end else begin
      m_fail();
    end
  endfunction

  function automatic void m_step(logic [4:1] b, logic sc, logic [11:0] ci);
    bit press = (b != 0) && (b != m_prev);
    int dig = 0;
    if ($onehot(b))
      for (int i = 1; i <= 4; i++) if (b[i]) dig = i;
    m_prev = b;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (press) begin
          m_ent.push_back(dig);
          m_since = 0;
          m_mode  = M_ENTRY;
          if (m_ent.size() == CODE_LEN) m_finish();
        end else if (m_mode == M_ENTRY) begin
          m_since++;
          if (m_since == TIMEOUT) m_fail();
        end
      end
      M_OPEN: begin
        if (sc) begin
          for (int k = 0; k < CODE_LEN; k++) m_code[k] = int'(ci[k*3 +: 3]);
          m_left = OPEN_HOLD;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      M_FAIL: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = M_IDLE;
          m_fails = 0;
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cycle++;
    if (rs) begin
      m_mode  = M_IDLE;
      m_code  = '{1, 3, 2, 4};
      m_ent.delete();
      m_since = 0;
      m_left  = 0;
      m_fails = 0;
      m_prev  = '0;
    end else begin
      m_step(btn, set_code, code_in);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [4:0] exp_v, act_v;
  always @(negedge clk) begin
    if (cycle > 0) begin
      exp_v = {m_mode == M_OPEN, (m_mode == M_FAIL) || (m_mode == M_LOCK),
               m_mode == M_LOCK, 2'(m_fails)};
      act_v = {led_green, led_red, locked, fail_cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d act(g,r,l,cnt)=%b required=%b", cycle, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [4:1] b, input logic sc = 1'b0, input logic [11:0] ci = '0);
    @(negedge clk);
    #1;
    btn      = b;
    set_code = sc;
    code_in  = ci;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000);
  endtask

  // first press in the least-significant nibble
  task automatic play4(input logic [15:0] seq);
    logic [4:1] b;
    for (int k = 0; k < 4; k++) begin
      b = seq[k*4 +: 4];
      cyc(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rs       = 1'b1;
    btn      = '0;
    set_code = 1'b0;
    #1;
    lit("async_reset_outputs", {led_green, led_red, locked, fail_cnt}, 0);
    @(negedge clk);
    #1;
    rs = 1'b0;
  endtask

  task automatic play_model_code();
    logic [4:1] b;
    for (int k = 0; k < CODE_LEN; k++) begin
      b = 4'(1 << (m_code[k] - 1));
      cyc(b);
      cyc(4'b0000);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] rnd_code;
  logic [4:1]  rb;
  int          r;

  initial begin
    #1 rs = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    lit("reset_state", {led_green, led_red, locked, fail_cnt}, 0);
    rs = 1'b0;

    // default code 1-3-2-4 opens for OPEN_HOLD cycles
    play4(16'h8241);
    cyc(4'b0000);
    lit("open_green", led_green, 1);
    lit("open_failcnt", fail_cnt, 0);
    idle(19);
    lit("open_green_last", led_green, 1);
    cyc(4'b0000);
    lit("open_green_end", led_green, 0);

    // wrong code 1-2-3-4 fails for FAIL_HOLD cycles
    do_reset();
    play4(16'h8421);
    cyc(4'b0000);
    lit("wrong_red", led_red, 1);
    lit("wrong_failcnt", fail_cnt, 1);
    lit("wrong_green", led_green, 0);
    idle(9);
    lit("wrong_red_last", led_red, 1);
    cyc(4'b0000);
    lit("wrong_red_end", led_red, 0);

    // held button counts once, then entry times out
    do_reset();
    cyc(4'b0001);
    cyc(4'b1000);
    cyc(4'b1000);
    idle(9);
    lit("timeout_not_yet", led_red, 0);
    cyc(4'b0000);
    lit("timeout_red", led_red, 1);
    lit("timeout_failcnt", fail_cnt, 1);

    // three wrong codes -> lockout; correct code ignored meanwhile
    do_reset();
    for (int i = 0; i < 3; i++) begin
      play4(16'h8421);
      cyc(4'b0000);
      lit("lock_failcnt", fail_cnt, i + 1);
      if (i < 2) idle(11);
    end
    lit("lock_locked", locked, 1);
    lit("lock_red", led_red, 1);
    play4(16'h8241);
    cyc(4'b0000);
    lit("lock_ignore_green", led_green, 0);
    idle(44);
    lit("lock_locked_last", locked, 1);
    cyc(4'b0000);
    lit("lock_released", locked, 0);
    lit("lock_failcnt_clr", fail_cnt, 0);

    // reprogram to 4-4-1-2 in OPEN; hold timer restarts on set_code
    do_reset();
    play4(16'h8241);
    cyc(4'b0000);
    cyc(4'b0000, 1'b1, 12'h464);
    cyc(4'b0000);
    idle(19);
    lit("setcode_hold_restart", led_green, 1);
    cyc(4'b0000);
    lit("setcode_hold_end", led_green, 0);
    cyc(4'b0000, 1'b1, 12'h249);
    idle(3);
    play4(16'h8241);
    cyc(4'b0000);
    lit("old_code_red", led_red, 1);
    idle(11);
    cyc(4'b1000); cyc(4'b0000); cyc(4'b1000); cyc(4'b0001); cyc(4'b0010);
    cyc(4'b0000);
    lit("new_code_green", led_green, 1);
    lit("new_code_failcnt", fail_cnt, 0);

    // multi-button digit fails; reset mid-entry discards partial entry
    do_reset();
    play4(16'h8243);
    cyc(4'b0000);
    lit("multibit_red", led_red, 1);
    do_reset();
    cyc(4'b0001);
    cyc(4'b0100);
    do_reset();
    play4(16'h8241);
    cyc(4'b0000);
    lit("fresh_after_reset", led_green, 1);

    // randomized phase
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else if (r < 5) begin
        play_model_code();
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      rb = 4'b0000;
        else if (r < 9) rb = 4'(1 << $urandom_range(0, 3));
        else            rb = 4'($urandom_range(0, 15));
        rnd_code = '0;
        for (int k = 0; k < CODE_LEN; k++) rnd_code[k*3 +: 3] = 3'($urandom_range(1, 4));
        cyc(rb, ($urandom_range(0, 19) == 0), rnd_code);
      end
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
